// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit -- multiply/divide unit for the E stage of the pipelined MIPS core.
//
// Executes mult/multu/div/divu as multi-cycle operations on operands latched at
// issue, and owns the HI/LO architectural registers. mthi/mtlo write HI/LO in a
// single cycle. The hazard unit watches `busy` and stalls any later
// HI/LO-touching instruction until it drops.
//
// Ports:
//   clk     in   1   system clock, all state updates on rising edge
//   reset   in   1   synchronous, active-high reset
//   start   in   1   E-stage instruction is a valid MDU op this cycle
//   mdu_op  in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                    7 reserved (no-op)
//   rs_val  in  32   operand A (multiplicand / dividend / mthi-mtlo source)
//   rt_val  in  32   operand B (multiplier / divisor)
//   busy    out  1   multi-cycle operation in progress
//   hi      out 32   HI register
//   lo      out 32   LO register
//   done    out  1   one-cycle pulse on the cycle HI/LO take a mult/div result
// -----------------------------------------------------------------------------
module mdu_unit #(
  parameter int MULT_CYCLES = 5,   // busy duration for mult/multu (>= 1)
  parameter int DIV_CYCLES  = 10   // busy duration for div/divu (>= 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e      r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  // Operands and opcode captured at issue; the result is computed only from
  // these, so forwarding-mux changes during BUSY cannot disturb it.
  mdu_op_e     r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  mdu_op_e     w_op;
  state_e      w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic        w_done_nxt;
  logic        w_latch;

  // ---------------------------------------------------------------------------
  // Arithmetic datapath (combinational on latched operands)
  // ---------------------------------------------------------------------------
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_is_sdiv;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_uquo;
  logic [31:0] w_urem;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_div_by_zero;
  logic [63:0] w_result;

  assign w_op = mdu_op_e'(mdu_op);

  // Sign/zero-extend to 64 bits so the low 64 bits of the product are the
  // exact two's-complement (or unsigned) result.
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed division runs as unsigned division on magnitudes, then restores
  // signs: quotient truncates toward zero, remainder follows the dividend.
  // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 / 1 negates back
  // to 0x80000000 with remainder 0.
  assign w_is_sdiv = (r_op == OP_DIV);
  assign w_a_neg   = w_is_sdiv & r_a[31];
  assign w_b_neg   = w_is_sdiv & r_b[31];
  assign w_a_mag   = w_a_neg ? (~r_a + 32'd1) : r_a;
  assign w_b_mag   = w_b_neg ? (~r_b + 32'd1) : r_b;

  // Guarded so a zero divisor never feeds the divider; the result is
  // discarded in that case anyway.
  assign w_uquo = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
  assign w_urem = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);

  assign w_quo = (w_a_neg ^ w_b_neg) ? (~w_uquo + 32'd1) : w_uquo;
  assign w_rem = w_a_neg ? (~w_urem + 32'd1) : w_urem;

  assign w_div_by_zero = ((r_op == OP_DIV) || (r_op == OP_DIVU)) && (r_b == 32'd0);

  always_comb begin
    case (r_op)
      OP_MULT:  w_result = w_prod_s;
      OP_MULTU: w_result = w_prod_u;
      OP_DIV,
      OP_DIVU:  w_result = {w_rem, w_quo};
      default:  w_result = {r_hi, r_lo};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next-state and register updates
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case, so no path leaves a
  // combinational output unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (w_op)
            OP_MULT, OP_MULTU: begin
              w_latch     = 1'b1;
              w_cnt_nxt   = CW'(MULT_CYCLES);
              w_state_nxt = ST_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              w_latch     = 1'b1;
              w_cnt_nxt   = CW'(DIV_CYCLES);
              w_state_nxt = ST_BUSY;
            end
            OP_MTHI: w_hi_nxt = rs_val;
            OP_MTLO: w_lo_nxt = rs_val;
            default: ;  // OP_NONE / OP_RSVD: nothing happens
          endcase
        end
      end

      ST_BUSY: begin
        // Any start here (including on the final edge) is ignored; the
        // hazard unit holds the instruction until busy is seen low.
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          if (!w_div_by_zero) begin
            w_hi_nxt = w_result[63:32];
            w_lo_nxt = w_result[31:0];
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and ordering between blocks is irrelevant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // NOTE: the operand latches are deliberately left out of reset; they are
  // only consumed in BUSY, which is always entered through a load.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_op <= w_op;
      r_a  <= rs_val;
      r_b  <= rt_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all straight from registers
  // ---------------------------------------------------------------------------
  assign busy = (r_state == ST_BUSY);
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;

endmodule

// File: tb/tb_mdu_unit.sv
// -----------------------------------------------------------------------------
// tb_mdu_unit -- self-checking bench for mdu_unit.
//
// Directed cases plus randomized operations, each compared against a small
// arithmetic reference model of HI/LO kept in the bench.
// -----------------------------------------------------------------------------
module tb_mdu_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;

  int n_total = 0;
  int n_bad   = 0;

  // Reference architectural state.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_unit #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdu_op(mdu_op),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {hi, lo} after a mult/div op, from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sp, sq, sr;
    longint unsigned up;
    logic [63:0]     r;
    r = {m_hi, m_lo};
    case (op)
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        r  = sp;
      end
      3'd2: begin
        up = 64'(a) * 64'(b);
        r  = up;
      end
      3'd3: if (b != 0) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        r  = {sr[31:0], sq[31:0]};
      end
      3'd4: if (b != 0) r = {a % b, a / b};
      default: ;
    endcase
    return r;
  endfunction

  // Issue one op with start=1 for a single edge and check the outcome.
  // With disturb set, inputs (including spurious starts) are randomized every
  // cycle of the busy period.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb);
    logic [63:0] exp;
    int          n, cyc, early;
    start  = 1'b1;
    mdu_op = op;
    rs_val = a;
    rt_val = b;
    if (op >= 3'd1 && op <= 3'd4) begin
      exp = ref_result(op, a, b);
      n   = (op <= 3'd2) ? MULT_CYCLES : DIV_CYCLES;
      @(posedge clk); #1;
      cyc   = 0;
      early = 0;
      while (busy === 1'b1 && cyc <= n + 4) begin
        cyc++;
        if (done !== 1'b0) early++;
        if (disturb) begin
          start  = 1'($urandom_range(0, 1));
          mdu_op = 3'($urandom_range(0, 7));
          rs_val = $urandom;
          rt_val = $urandom;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
      end
      start = 1'b0;
      check("busy_cycles", 64'(cyc), 64'(n));
      check("early_done", 64'(early), 64'd0);
      check("done_pulse", 64'(done), 64'd1);
      check("hi", 64'(hi), 64'(exp[63:32]));
      check("lo", 64'(lo), 64'(exp[31:0]));
      m_hi = exp[63:32];
      m_lo = exp[31:0];
      @(posedge clk); #1;
      check("done_clear", 64'(done), 64'd0);
      check("hi_hold", 64'(hi), 64'(m_hi));
    end else begin
      if (op == 3'd5) m_hi = a;
      if (op == 3'd6) m_lo = a;
      @(posedge clk); #1;
      start = 1'b0;
      check("move_busy", 64'(busy), 64'd0);
      check("move_done", 64'(done), 64'd0);
      check("move_hi", 64'(hi), 64'(m_hi));
      check("move_lo", 64'(lo), 64'(m_lo));
    end
  endtask

  initial begin
    int          seen;
    logic [2:0]  op;
    logic [31:0] a, b;

    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = 3'd0;
    rs_val = '0;
    rt_val = '0;
    m_hi   = '0;
    m_lo   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    // Reset in the middle of a mult discards it; HI/LO made nonzero first.
    run_op(3'd5, 32'h0000_1234, 32'd0, 1'b0);
    run_op(3'd6, 32'h0000_5678, 32'd0, 1'b0);
    start = 1'b1; mdu_op = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_hi", 64'(hi), 64'd0);
    check("rstmid_lo", 64'(lo), 64'd0);
    seen = 0;
    for (int i = 0; i < DIV_CYCLES + 2; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("rstmid_no_done", 64'(seen), 64'd0);

    // Directed arithmetic cases.
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("mult_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("multu_hi_const", 64'(hi), 64'h0000_0000_0000_0001);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    check("div_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    run_op(3'd4, 32'd7, 32'd2, 1'b0);
    check("divu_lo_const", 64'(lo), 64'd3);
    check("divu_hi_const", 64'(hi), 64'd1);

    // Division by zero leaves preloaded HI/LO untouched.
    run_op(3'd5, 32'h0000_0011, 32'd0, 1'b0);
    run_op(3'd6, 32'h0000_0022, 32'd0, 1'b0);
    run_op(3'd3, 32'h1234_5678, 32'd0, 1'b0);
    check("div0_hi_const", 64'(hi), 64'h11);
    check("div0_lo_const", 64'(lo), 64'h22);
    run_op(3'd4, 32'hFFFF_0000, 32'd0, 1'b0);

    // Signed overflow case.
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("ovf_lo_const", 64'(lo), 64'h8000_0000);
    check("ovf_hi_const", 64'(hi), 64'h0);

    run_op(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);

    // mtlo attempted while a mult is busy: ignored, LO ends with the product.
    start = 1'b1; mdu_op = 3'd1; rs_val = 32'd1000; rt_val = 32'd7;
    @(posedge clk); #1;
    mdu_op = 3'd6; rs_val = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    while (busy === 1'b1 && seen < MULT_CYCLES + 4) begin
      @(posedge clk); #1;
      seen++;
    end
    check("mtlo_busy_lo", 64'(lo), 64'd7000);
    check("mtlo_busy_hi", 64'(hi), 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd7000;

    // No-op encodings and start=0 change nothing.
    run_op(3'd0, 32'h5555_5555, 32'h1, 1'b0);
    run_op(3'd7, 32'hAAAA_AAAA, 32'h1, 1'b0);
    mdu_op = 3'd1; rs_val = 32'h7; rt_val = 32'h9;
    @(posedge clk); #1;
    check("nostart_busy", 64'(busy), 64'd0);
    check("nostart_lo", 64'(lo), 64'(m_lo));

    // Randomized operations, some with inputs churning during busy.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      run_op(op, a, b, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the pipelined MIPS core. Executes mult/multu/div/divu over several cycles and holds the HI/LO architectural registers.
- Takes rs/rt operands after forwarding muxes. Exposes `busy` to the hazard unit, which stalls any later HI/LO-touching instruction.
- mfhi/mflo read `hi`/`lo` directly, with no extra latency.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (>=1)
- DIV_CYCLES, 10, cycles busy stays high for div/divu (>=1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is a valid MDU op this cycle (already gated by stall/flush)
- mdu_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved(no-op)
- rs_val  input  32  operand A (dividend / mthi-mtlo source)
- rt_val  input  32  operand B (divisor)
- busy  output  1  multi-cycle operation in progress
- hi  output  32  HI register
- lo  output  32  LO register
- done  output  1  one-cycle pulse on the cycle HI/LO take a mult/div result

Behaviour:
- Reset (sync, high): busy=0, done=0, hi=0, lo=0, counter=0, state=IDLE. Overrides every other input on the same edge. Reset mid-operation discards the pending result.
- States: IDLE, BUSY.
- IDLE, start=1, mdu_op in {1..4} at edge T:
  - Latch rs_val, rt_val and op.
  - Counter loads MULT_CYCLES or DIV_CYCLES; state -> BUSY; busy=1 after edge T.
- BUSY: counter decrements each edge. On the edge where counter reaches 0 (edge T+N, N = cycle parameter):
  - hi/lo update with the result.
  - busy -> 0, done=1 for exactly one cycle; state -> IDLE.
  - busy is therefore high for exactly N cycles.
- Results are computed on the latched operands only; input changes during BUSY have no effect. Result may be computed combinationally and registered at the final edge.
- mthi/mtlo, IDLE, start=1: hi (or lo) <= rs_val at that edge; busy stays 0, no done.
- Any start while BUSY is ignored: no restart, no mthi/mtlo write. The hazard unit guarantees this never happens legally.
- mdu_op 0 or 7, or start=0: no state change.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 -> 64.
  - div: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Division by zero (div/divu): full busy period runs, done pulses, hi/lo unchanged.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, no exception.
- Start on the same edge that busy falls: that edge is the BUSY->IDLE edge, so start is ignored. The hazard unit keeps the instruction stalled until busy=0 is seen.
- hi/lo outputs are register outputs: stable for the whole cycle, no combinational path from inputs.

Test Plan:
- Reset mid-op: start mult with rs=3, rt=4; assert reset after 2 cycles -> next edge busy=0, hi=lo=0; no done pulse ever follows.
- mult rs=0xFFFFFFFF rt=0x00000002 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE, done pulses once.
- multu same operands -> hi=0x00000001 lo=0xFFFFFFFE after 5 cycles.
- div rs=0xFFFFFFF9(-7) rt=2 -> after 10 cycles lo=0xFFFFFFFD hi=0xFFFFFFFF.
- divu rs=7 rt=2 -> lo=3 hi=1.
- div rt=0 with hi=0x11, lo=0x22 preloaded via mthi/mtlo -> after 10 cycles done=1, hi=0x11 lo=0x22 unchanged.
- mthi rs=0xDEADBEEF -> hi=0xDEADBEEF next edge, busy stays 0.
- mtlo issued during a mult busy period -> lo ignored, ends holding the mult result.
- Change rs/rt every cycle while busy -> result matches operands latched at start.
